two_bit_counter: RTL and testbench

- 2-bit synchronous up-counter with a count-enable input `x`, state output `Q`, and Mealy terminal-count output `z`.
- Implemented as a 4-state FSM: S0=00, S1=01, S2=10, S3=11.
- Used as a small sequencing/timing element in lab-level designs. Can be cascaded via `z` as the carry into the next stage's `x`.

---
 rtl/two_bit_counter.sv | 63 ++++++
 tb/tb_two_bit_counter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/two_bit_counter.sv
// 2-bit enabled up-counter FSM with terminal-count carry z.
// Define TWO_BIT_COUNTER_REGZ_EN to register z (one cycle later than Mealy).
module two_bit_counter #(
  parameter logic [1:0] RESET_VALUE = 2'b00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       x,
  output logic [1:0] Q,
  output logic       z
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   tc;

  assign tc = x & (state == S3);

  always_comb begin
    state_nxt = state;
    if (x) begin
      unique case (state)
        S0: state_nxt = S1;
        S1: state_nxt = S2;
        S2: state_nxt = S3;
        S3: state_nxt = S0;
      endcase
    end
  end

`ifdef TWO_BIT_COUNTER_REGZ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= state_t'(RESET_VALUE);
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      z     <= tc;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= state_t'(RESET_VALUE);
    end else begin
      state <= state_nxt;
    end
  end

  // Mealy carry: not gated by reset
  assign z = tc;
`endif

  assign Q = state;

endmodule

// File: tb/tb_two_bit_counter.sv
// Scoreboard bench for two_bit_counter: directed vectors, negedge monitor.
// Expected z column selected by TWO_BIT_COUNTER_REGZ_EN.
module tb_two_bit_counter;

  logic       clk;
  logic       reset;
  logic       x;
  logic [1:0] Q;
  logic       z;

  two_bit_counter #(.RESET_VALUE(2'b00)) dut (
    .clk  (clk),
    .reset(reset),
    .x    (x),
    .Q    (Q),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [1:0] q;
    logic       z;
  } exp_t;

  typedef struct {
    logic       r;
    logic       x;
    logic [1:0] q;
    logic       zc;
    logic       zr;
  } vec_t;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;
  bit   stim_done;

  localparam int NV = 26;
  vec_t vt[NV];

  // {reset, x, Q seen this cycle, Mealy z, registered z}
  initial begin
    vt[0]  = '{1, 1, 2'b00, 0, 0};
    vt[1]  = '{1, 0, 2'b00, 0, 0};
    vt[2]  = '{0, 1, 2'b00, 0, 0};
    vt[3]  = '{0, 1, 2'b01, 0, 0};
    vt[4]  = '{0, 1, 2'b10, 0, 0};
    vt[5]  = '{0, 1, 2'b11, 1, 0};
    vt[6]  = '{0, 1, 2'b00, 0, 1};
    vt[7]  = '{0, 1, 2'b01, 0, 0};
    vt[8]  = '{0, 0, 2'b10, 0, 0};
    vt[9]  = '{0, 0, 2'b10, 0, 0};
    vt[10] = '{0, 0, 2'b10, 0, 0};
    vt[11] = '{0, 1, 2'b10, 0, 0};
    vt[12] = '{1, 1, 2'b11, 1, 0};
    vt[13] = '{0, 1, 2'b00, 0, 0};
    vt[14] = '{1, 0, 2'b01, 0, 0};
    vt[15] = '{0, 0, 2'b00, 0, 0};
    vt[16] = '{0, 1, 2'b00, 0, 0};
    vt[17] = '{0, 0, 2'b01, 0, 0};
    vt[18] = '{0, 1, 2'b01, 0, 0};
    vt[19] = '{0, 0, 2'b10, 0, 0};
    vt[20] = '{0, 1, 2'b10, 0, 0};
    vt[21] = '{0, 0, 2'b11, 0, 0};
    vt[22] = '{0, 1, 2'b11, 1, 0};
    vt[23] = '{0, 0, 2'b00, 0, 1};
    vt[24] = '{0, 1, 2'b00, 0, 0};
    vt[25] = '{0, 0, 2'b01, 0, 0};
  end

  initial begin
    exp_t e;
    n_chk     = 0;
    n_fail    = 0;
    stim_done = 0;
    // first edge is a reset edge; Q is unknown before it
    reset = 1'b1;
    x     = 1'b0;
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      reset = vt[i].r;
      x     = vt[i].x;
      e.idx = i;
      e.q   = vt[i].q;
`ifdef TWO_BIT_COUNTER_REGZ_EN
      e.z   = vt[i].zr;
`else
      e.z   = vt[i].zc;
`endif
      sb.push_back(e);
    end
    @(posedge clk);
    @(posedge clk);
    stim_done = 1;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_chk++;
        if (Q !== e.q) begin
          n_fail++;
          $display("FAIL q[%0d]: got %b want %b", e.idx, Q, e.q);
        end
        n_chk++;
        if (z !== e.z) begin
          n_fail++;
          $display("FAIL z[%0d]: got %b want %b", e.idx, z, e.z);
        end
      end
    end
  end

  initial begin
    fork
      wait (stim_done);
      #5000;
    join_any
    disable fork;
    n_chk++;
    if (!stim_done) begin
      n_fail++;
      $display("FAIL timeout: got done=0 want done=1");
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d left want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
